// File: rtl/dffram_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dffram_rr_arbiter                                               |
// | Purpose  : Two-port round-robin arbiter with ownership lock in front of a  |
// |            single-port DFFRAM macro; read data is routed to its issuer.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dffram_rr_arbiter #(
  parameter int AW       = 7,
  parameter bit P0_FIRST = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,

  input  logic          p0_req,
  input  logic          p0_lock,
  input  logic [3:0]    p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,

  input  logic          p1_req,
  input  logic          p1_lock,
  input  logic [3:0]    p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,

  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [1:0] c_FREE     = 2'd0;
  localparam logic [1:0] c_OWN0     = 2'd1;
  localparam logic [1:0] c_OWN1     = 2'd2;
  // r_last = 1 means port 1 was granted last, so port 0 wins the next contention.
  localparam logic       c_LAST_RST = P0_FIRST ? 1'b1 : 1'b0;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_last;
  logic        r_tag_valid;
  logic        r_tag_port;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [3:0]  w_we;
  logic        w_rd_issue;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      c_FREE: begin
        if (p0_req && p1_req) begin
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end else begin
          w_gnt0 = p0_req;
          w_gnt1 = p1_req;
        end
      end
      c_OWN0:  w_gnt0 = p0_req;
      c_OWN1:  w_gnt1 = p1_req;
      default: begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    endcase
  end

  // Lock is only looked at together with a grant; an idle owner keeps the RAM.
  always_comb begin
    w_state_nxt = r_state;
    if (w_gnt0) begin
      w_state_nxt = p0_lock ? c_OWN0 : c_FREE;
    end else if (w_gnt1) begin
      w_state_nxt = p1_lock ? c_OWN1 : c_FREE;
    end else if (r_state != c_OWN0 && r_state != c_OWN1) begin
      w_state_nxt = c_FREE;
    end
  end

  always_comb begin
    w_we = 4'h0;
    if (w_gnt0) begin
      w_we = p0_we;
    end else if (w_gnt1) begin
      w_we = p1_we;
    end
  end

  assign w_rd_issue = (w_gnt0 || w_gnt1) && (w_we == 4'h0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= c_FREE;
      r_last      <= c_LAST_RST;
      r_tag_valid <= 1'b0;
      r_tag_port  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tag_valid <= w_rd_issue;
      if (w_gnt0 || w_gnt1) begin
        r_last     <= w_gnt1;
        r_tag_port <= w_gnt1;
      end
    end
  end

  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;

  assign ram_en    = w_gnt0 | w_gnt1;
  assign ram_we    = w_we;
  assign ram_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign ram_wdata = w_gnt1 ? p1_wdata : p0_wdata;

  assign p0_rvalid = r_tag_valid & ~r_tag_port;
  assign p1_rvalid = r_tag_valid &  r_tag_port;
  assign p0_rdata  = ram_rdata;
  assign p1_rdata  = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dffram_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dffram_rr_arbiter                                            |
// | Purpose  : Self-checking bench for dffram_rr_arbiter with a DFFRAM model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dffram_rr_arbiter;

  localparam int AW = 7;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          p0_req, p0_lock, p1_req, p1_lock;
  logic [3:0]    p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  dffram_rr_arbiter #(.AW(AW), .P0_FIRST(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // DFFRAM macro: registered read, byte-masked write.
  logic [31:0] mem [0:127];
  always @(posedge HCLK) begin
    if (ram_en) begin
      if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
      else                mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_we);
    end
  end

  // Reference model: owner (-1 = nobody), last granted port, pending read, golden memory.
  int          m_owner;
  int          m_last;
  bit          m_pend;
  int          m_pend_port;
  logic [31:0] m_pend_data;
  logic [31:0] gold [0:127];
  bit          e_g0, e_g1;
  logic [3:0]  e_we;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_pend  = 1'b0;
  endtask

  task automatic predict();
    int w;
    w = -1;
    if (m_owner == 0) begin
      if (p0_req) w = 0;
    end else if (m_owner == 1) begin
      if (p1_req) w = 1;
    end else if (p0_req && p1_req) begin
      w = 1 - m_last;
    end else if (p0_req) begin
      w = 0;
    end else if (p1_req) begin
      w = 1;
    end
    e_g0 = (w == 0);
    e_g1 = (w == 1);
    e_we = e_g0 ? p0_we : (e_g1 ? p1_we : 4'h0);
  endtask

  task automatic sample();
    @(negedge HCLK);
    predict();
  endtask

  task automatic tick();
    int          w;
    logic        lk;
    logic [3:0]  we;
    logic [6:0]  ad;
    logic [31:0] wd;
    predict();
    w = e_g0 ? 0 : (e_g1 ? 1 : -1);
    @(posedge HCLK);
    m_pend = 1'b0;
    if (w >= 0) begin
      lk = (w == 0) ? p0_lock  : p1_lock;
      we = (w == 0) ? p0_we    : p1_we;
      ad = (w == 0) ? p0_addr  : p1_addr;
      wd = (w == 0) ? p0_wdata : p1_wdata;
      m_last  = w;
      m_owner = lk ? w : -1;
      if (we == 4'h0) begin
        m_pend      = 1'b1;
        m_pend_port = w;
        m_pend_data = gold[ad];
      end else begin
        gold[ad] = merge(gold[ad], wd, we);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_lock = 1'b0; p0_we = 4'h0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_lock = 1'b0; p1_we = 4'h0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b0;
    model_reset();
    #2;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid_in_reset: got %b expected 00", {p0_rvalid, p1_rvalid}); end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    sample();
    checks++; if ({p0_gnt, p1_gnt, ram_en} !== 3'b000) begin errors++; $display("FAIL reset_gnt_en: got %b expected 000", {p0_gnt, p1_gnt, ram_en}); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL reset_ram_we: got %h expected 0", ram_we); end
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid}); end
    tick();
  endtask

  task automatic test_single_read();
    idle_inputs();
    p0_req = 1'b1; p0_addr = 7'd5;
    sample();
    checks++; if ({p0_gnt, p1_gnt, ram_en} !== 3'b101) begin errors++; $display("FAIL single_read_gnt: got %b expected 101", {p0_gnt, p1_gnt, ram_en}); end
    checks++; if (ram_we !== 4'h0 || ram_addr !== 7'd5) begin errors++; $display("FAIL single_read_cmd: got we=%h addr=%0d expected we=0 addr=5", ram_we, ram_addr); end
    tick();
    idle_inputs();
    sample();
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b10) begin errors++; $display("FAIL single_read_rvalid: got %b expected 10", {p0_rvalid, p1_rvalid}); end
    checks++; if (p0_rdata !== gold[5]) begin errors++; $display("FAIL single_read_data: got %h expected %h", p0_rdata, gold[5]); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    p0_req = 1'b1; p0_we = 4'h0; p0_addr = 7'd0;
    p1_req = 1'b1; p1_we = 4'hF; p1_addr = 7'd64; p1_wdata = $urandom;
    for (int k = 0; k < 10; k++) begin
      bit exp0, prev0;
      sample();
      exp0 = (k % 2 == 0);
      checks++; if ({p0_gnt, p1_gnt} !== {exp0, ~exp0}) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, {p0_gnt, p1_gnt}, {exp0, ~exp0}); end
      prev0 = (k > 0) && ((k - 1) % 2 == 0);
      checks++; if (p0_rvalid !== prev0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b%b expected %b0", k, p0_rvalid, p1_rvalid, prev0); end
      if (prev0) begin
        checks++; if (p0_rdata !== m_pend_data) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, p0_rdata, m_pend_data); end
      end
      tick();
      if (exp0) p0_addr = p0_addr + 7'd1;
      else begin p1_addr = p1_addr + 7'd1; p1_wdata = $urandom; end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_then_read();
    idle_inputs();
    p1_req = 1'b1; p1_we = 4'hF; p1_addr = 7'd127; p1_wdata = 32'hDEADBEEF;
    sample();
    checks++; if ({p0_gnt, p1_gnt, ram_we} !== 6'b01_1111) begin errors++; $display("FAIL wr_rd_write: got gnt=%b%b we=%h expected 01 F", p0_gnt, p1_gnt, ram_we); end
    tick();
    idle_inputs();
    p0_req = 1'b1; p0_addr = 7'd127;
    sample();
    checks++; if ({p0_gnt, p1_rvalid, p0_rvalid} !== 3'b100) begin errors++; $display("FAIL wr_rd_read_gnt: got %b expected 100", {p0_gnt, p1_rvalid, p0_rvalid}); end
    tick();
    idle_inputs();
    sample();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got v=%b %h expected 1 deadbeef", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_lock();
    idle_inputs();
    p1_req = 1'b1; p1_we = 4'hF; p1_addr = 7'd10; p1_wdata = 32'h0BADF00D;
    tick();
    p0_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p0_lock = (k < 2); p0_addr = 7'(20 + k);
      sample();
      checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_seq[%0d]: got %b expected 10", k, {p0_gnt, p1_gnt}); end
      tick();
    end
    p0_req = 1'b0; p0_lock = 1'b0;
    sample();
    checks++; if ({p0_gnt, p1_gnt, p0_rvalid} !== 3'b011) begin errors++; $display("FAIL lock_release: got %b expected 011", {p0_gnt, p1_gnt, p0_rvalid}); end
    checks++; if (p0_rdata !== gold[22]) begin errors++; $display("FAIL lock_rdata: got %h expected %h", p0_rdata, gold[22]); end
    tick();
    // Owner idles while holding the lock: the other port must stay blocked.
    p1_req = 1'b0;
    p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 7'd30;
    sample();
    tick();
    p0_req = 1'b0; p0_lock = 1'b0; p1_req = 1'b1;
    sample();
    checks++; if ({p0_gnt, p1_gnt, ram_en} !== 3'b000) begin errors++; $display("FAIL lock_idle_owner: got %b expected 000", {p0_gnt, p1_gnt, ram_en}); end
    tick();
    p0_req = 1'b1; p0_addr = 7'd31;
    sample();
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_owner_final: got %b expected 10", {p0_gnt, p1_gnt}); end
    tick();
    p0_req = 1'b0;
    sample();
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL lock_after_final: got %b expected 01", {p0_gnt, p1_gnt}); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_byte_write();
    idle_inputs();
    p0_req = 1'b1; p0_we = 4'hF; p0_addr = 7'd40; p0_wdata = 32'h11223344;
    tick();
    p0_we = 4'b0010; p0_wdata = 32'h0000AB00;
    sample();
    checks++; if (ram_we !== 4'b0010 || ram_wdata !== 32'h0000AB00) begin errors++; $display("FAIL byte_cmd: got we=%b wd=%h expected 0010 0000ab00", ram_we, ram_wdata); end
    tick();
    p0_we = 4'h0;
    tick();
    idle_inputs();
    sample();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1122AB44) begin errors++; $display("FAIL byte_readback: got v=%b %h expected 1 1122ab44", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    p1_req = 1'b1; p1_lock = 1'b1; p1_addr = 7'd50;
    sample();
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 1", p1_gnt); end
    tick();
    idle_inputs();
    #1;
    checks++; if (p1_rvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b expected 1", p1_rvalid); end
    HRESETn = 1'b0;
    model_reset();
    #1;
    checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_drop: got %b expected 0", p1_rvalid); end
    HRESETn = 1'b1;
    p0_req = 1'b1; p0_addr = 7'd51;
    sample();
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL rst_mid_p0_gnt: got %b expected 10", {p0_gnt, p1_gnt}); end
    tick();
    idle_inputs();
    sample();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== gold[51]) begin errors++; $display("FAIL rst_mid_p0_data: got v=%b %h expected 1 %h", p0_rvalid, p0_rdata, gold[51]); end
    tick();
  endtask

  task automatic new_req(input int p);
    logic        rq, lk;
    logic [3:0]  we;
    logic [6:0]  ad;
    logic [31:0] wd;
    rq = ($urandom_range(0, 3) != 0);
    lk = ($urandom_range(0, 3) == 0);
    we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    ad = 7'($urandom_range(0, 7));
    wd = $urandom;
    if (p == 0) begin p0_req = rq; p0_lock = lk; p0_we = we; p0_addr = ad; p0_wdata = wd; end
    else        begin p1_req = rq; p1_lock = lk; p1_we = we; p1_addr = ad; p1_wdata = wd; end
  endtask

  task automatic test_random();
    new_req(0);
    new_req(1);
    for (int c = 0; c < 400; c++) begin
      bit g0, g1;
      sample();
      checks++; if ({p0_gnt, p1_gnt, ram_en} !== {e_g0, e_g1, e_g0 | e_g1}) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, {p0_gnt, p1_gnt, ram_en}, {e_g0, e_g1, e_g0 | e_g1}); end
      checks++; if (ram_we !== e_we) begin errors++; $display("FAIL rnd_we[%0d]: got %h expected %h", c, ram_we, e_we); end
      if (e_g0 || e_g1) begin
        checks++; if (ram_addr !== (e_g0 ? p0_addr : p1_addr)) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d expected %0d", c, ram_addr, e_g0 ? p0_addr : p1_addr); end
        if (e_we != 4'h0) begin
          checks++; if (ram_wdata !== (e_g0 ? p0_wdata : p1_wdata)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", c, ram_wdata, e_g0 ? p0_wdata : p1_wdata); end
        end
      end
      checks++; if ({p0_rvalid, p1_rvalid} !== {m_pend && m_pend_port == 0, m_pend && m_pend_port == 1}) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b%b expected %b%b", c, p0_rvalid, p1_rvalid, m_pend && m_pend_port == 0, m_pend && m_pend_port == 1); end
      if (m_pend) begin
        checks++; if (p0_rdata !== m_pend_data || p1_rdata !== m_pend_data) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h", c, p0_rdata, p1_rdata, m_pend_data); end
      end
      g0 = e_g0; g1 = e_g1;
      tick();
      if (!p0_req || g0) new_req(0);
      if (!p1_req || g1) new_req(1);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]  = $urandom;
      gold[i] = mem[i];
    end
    idle_inputs();
    model_reset();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_then_read();
    test_lock();
    test_byte_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
